// File: rtl/twos_comp_seq.sv
// Bit-serial two's-complement negator / pass-through.
// Takes one word per transaction and processes it LSB first, one bit per clock.
// It holds the result until the consumer takes it.
module twos_comp_seq #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             t_clk,
   input  logic             r_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_neg,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_ovf,
   output logic             busy
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] sreg;
   logic [WIDTH-1:0] rreg;
   logic [CW-1:0]    cnt;
   logic             seen;
   logic             mode;

   logic             bit_in;
   logic             res_bit;
   logic             last;

   // Serial datapath: invert every bit after the first one seen when negating
   always_comb begin
      bit_in   = sreg[0];
      res_bit  = mode ? (bit_in ^ seen) : bit_in;
      last     = (cnt == CW'(WIDTH - 1));
      in_ready = (state == IDLE);
   end

   // Control FSM with registered datapath and status outputs
   always_ff @(posedge t_clk or negedge r_n) begin
      if (!r_n) begin
         state     <= IDLE;
         sreg      <= '0;
         rreg      <= '0;
         cnt       <= '0;
         seen      <= 1'b0;
         mode      <= 1'b0;
         out_data  <= '0;
         out_ovf   <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  sreg  <= in_data;
                  mode  <= in_neg;
                  cnt   <= '0;
                  seen  <= 1'b0;
                  busy  <= 1'b1;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               sreg <= sreg >> 1;
               rreg <= {res_bit, rreg[WIDTH-1:1]};
               seen <= seen | bit_in;
               cnt  <= cnt + CW'(1);
               if (last) begin
                  out_data  <= {res_bit, rreg[WIDTH-1:1]};
                  // The only operand whose first set bit is the MSB is the most-negative value
                  out_ovf   <= mode & bit_in & ~seen;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               busy      <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_twos_comp_seq.sv
// Scoreboard bench for twos_comp_seq.
// The driver pushes expected results on acceptance. The monitor pops and compares them on each output handshake.
module tb_twos_comp_seq;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         r_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         in_neg;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic         out_ovf;
   logic         busy;

   typedef struct {
      logic [W-1:0] d;
      logic         ovf;
      int unsigned  acc;
   } exp_t;

   exp_t        q[$];
   int          total = 0;
   int          bad = 0;
   int unsigned cyc = 0;
   int unsigned last_acc = 0;
   int unsigned last_hs = 0;
   int unsigned nxfer = 0;
   int unsigned npush = 0;
   int unsigned rmode = 0;
   logic        prev_valid = 1'b0;

   twos_comp_seq #(.WIDTH(W)) dut (
      .t_clk    (clk),
      .r_n      (r_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_neg   (in_neg),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_ovf  (out_ovf),
      .busy     (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      total++;
      bad++;
      $display("FAIL %s: got timeout/unexpected expected event (cycle %0d)", name, cyc);
   endtask

   // Offer a word and wait, bounded, for it to be taken; then scramble the inputs
   task automatic send(input logic [W-1:0] x, input logic n, input logic [W-1:0] ed, input logic eo);
      exp_t        e;
      int unsigned k = 0;
      logic        ok = 1'b0;
      in_data  = x;
      in_neg   = n;
      in_valid = 1'b1;
      while (!ok && k < 400) begin
         @(negedge clk);
         if (in_ready && r_n) ok = 1'b1;
         else k++;
      end
      if (ok) begin
         e.d   = ed;
         e.ovf = eo;
         e.acc = cyc + 1;
         q.push_back(e);
         npush++;
         last_acc = cyc + 1;
      end else begin
         fail_now("accept_timeout");
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = W'($urandom);
      in_neg   = 1'($urandom);
   endtask

   task automatic drain();
      int unsigned k = 0;
      while (q.size() > 0 && k < 400) begin
         @(negedge clk);
         k++;
      end
      check("drain_empty", q.size(), 0);
   endtask

   // Consumer ready: 0 = always ready, 1 = random, 2 = stalled
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rmode)
            0: out_ready = 1'b1;
            1: out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
         endcase
      end
   end

   // Monitor: latency on rising out_valid, data/ovf on each handshake
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!r_n) begin
            prev_valid = 1'b0;
         end else begin
            if (out_valid && !prev_valid) begin
               if (q.size() == 0) fail_now("unexpected_valid");
               else check("latency", cyc - q[0].acc, W);
            end
            if (out_valid && out_ready) begin
               if (q.size() == 0) begin
                  fail_now("spurious_result");
               end else begin
                  e = q.pop_front();
                  check("out_data", out_data, e.d);
                  check("out_ovf", out_ovf, e.ovf);
                  nxfer++;
                  last_hs = cyc + 1;
               end
            end
            prev_valid = out_valid;
         end
      end
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // Hand-computed directed vectors: operand, negate, result, overflow
   logic [W-1:0] vx [8] = '{8'h06, 8'h5A, 8'h00, 8'h80, 8'hFF, 8'h01, 8'h7F, 8'h80};
   logic         vn [8] = '{1'b1,  1'b0,  1'b1,  1'b1,  1'b1,  1'b1,  1'b1,  1'b0};
   logic [W-1:0] vd [8] = '{8'hFA, 8'h5A, 8'h00, 8'h80, 8'h01, 8'hFF, 8'h81, 8'h80};
   logic         vo [8] = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0};

   initial begin
      logic [W-1:0] x;
      logic         n;
      logic [W-1:0] ed;
      int unsigned  k;
      r_n      = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      in_neg   = 1'b0;
      #12;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_ovf", out_ovf, 0);
      @(posedge clk);
      #1;
      r_n = 1'b1;

      for (int i = 0; i < 8; i++) send(vx[i], vn[i], vd[i], vo[i]);
      drain();

      // Backpressure: stall the result, second word waits with in_valid high
      rmode = 2;
      @(posedge clk);
      #2;
      send(8'h06, 1'b1, 8'hFA, 1'b0);
      k = 0;
      while (!out_valid && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("bp_valid_seen", out_valid, 1);
      fork
         send(8'h01, 1'b1, 8'hFF, 1'b0);
      join_none
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("bp_out_valid", out_valid, 1);
         check("bp_out_data", out_data, 8'hFA);
         check("bp_in_ready", in_ready, 0);
         check("bp_busy", busy, 1);
      end
      rmode = 0;
      wait fork;
      check("bp_accept_spacing", last_acc, last_hs + 1);
      drain();

      // Reset in the middle of a word, then accept on the first edge after release
      send(8'h06, 1'b1, 8'hFA, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      r_n = 1'b0;
      #1;
      check("mid_rst_out_data", out_data, 0);
      check("mid_rst_out_ovf", out_ovf, 0);
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_in_ready", in_ready, 1);
      q.delete();
      npush--;
      in_data  = 8'h03;
      in_neg   = 1'b1;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      check("under_rst_busy", busy, 0);
      @(negedge clk);
      r_n = 1'b1;
      begin
         exp_t e;
         e.d   = 8'hFD;
         e.ovf = 1'b0;
         e.acc = cyc + 1;
         q.push_back(e);
         npush++;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("accept_after_rst", busy, 1);
      drain();

      // Random regression against an arithmetic reference
      rmode = 1;
      for (int i = 0; i < 1000; i++) begin
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
         x  = W'($urandom);
         n  = 1'($urandom);
         ed = n ? W'(9'h100 - {1'b0, x}) : x;
         send(x, n, ed, n && (x == 8'h80));
      end
      drain();
      check("xfer_count", nxfer, npush);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/twos_comp_seq.md
TWOS_COMP_SEQ -- requirements
Module: twos_comp_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the word length in bits; legal range 2..32.
REQ-002 SHALL have port t_clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port r_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  a word is offered on in_data/in_neg.
REQ-005 SHALL have port in_ready  output  1  the block can accept a word this cycle.
REQ-006 SHALL have port in_data  input  WIDTH  the operand word.
REQ-007 SHALL have port in_neg  input  1  1 = two's-complement negate, 0 = pass-through.
REQ-008 SHALL have port out_valid  output  1  out_data/out_ovf hold a completed result.
REQ-009 SHALL have port out_ready  input  1  the consumer takes the result this cycle.
REQ-010 SHALL have port out_data  output  WIDTH  the result word.
REQ-011 SHALL have port out_ovf  output  1  negation overflow: the operand was the most-negative value.
REQ-012 SHALL have port busy  output  1  the block is in SHIFT or DONE.

Function
REQ-013 SHALL implement an FSM with states IDLE, SHIFT and DONE, and no other reachable states.
REQ-014 SHALL drive in_ready=1 only in IDLE; out_valid=1 only in DONE; busy=1 in SHIFT and DONE.
REQ-015 SHALL accept a word on a rising edge with in_valid=1 and in_ready=1.
- On acceptance it SHALL latch in_data into a shift register and in_neg into a mode flag.
- It SHALL clear the bit counter and the seen-one flag, then go to SHIFT.
REQ-016 SHALL ignore in_data and in_neg at all times other than the acceptance edge.
REQ-017 SHALL process one bit per cycle in SHIFT, LSB first, with counter values 0..WIDTH-1.
REQ-018 SHALL compute each serial bit b as follows:
- If the mode flag is 1, the result bit SHALL be b XOR seen.
- If the mode flag is 0, the result bit SHALL be b.
- After each bit, seen SHALL become seen OR b.
REQ-019 SHALL shift each result bit into the MSB of a result register, so that after WIDTH bits out_data[k] equals result bit k.
REQ-020 SHALL move from SHIFT to DONE on the edge that processes bit WIDTH-1.
- Acceptance at edge E0 SHALL give out_valid=1 from edge E0+WIDTH.
- Fixed latency SHALL be WIDTH cycles.
REQ-021 SHALL compute out_ovf as 1 exactly when the mode flag is 1 and the operand equals 1 followed by WIDTH-1 zeros.
- In that case out_data SHALL equal the operand.
- out_ovf SHALL be valid while out_valid=1.
REQ-022 SHALL map a zero operand with in_neg=1 to out_data=0 and out_ovf=0.
REQ-023 SHALL hold out_data and out_ovf stable in DONE until a rising edge with out_ready=1, then return to IDLE.
REQ-024 SHALL deassert out_valid on the edge following a DONE-state handshake.
REQ-025 SHALL NOT assert in_ready in that same cycle; it is asserted in the next cycle (IDLE).
- Minimum word-to-word spacing SHALL be WIDTH+2 cycles.
REQ-026 SHALL remain in DONE with all outputs stable, for an unbounded time, while out_ready=0.
REQ-027 SHALL have no effect when out_ready is asserted outside DONE.
REQ-028 SHALL have no effect when in_valid is asserted outside IDLE; the word is not accepted.
REQ-029 SHALL keep out_data at its last result in IDLE and SHIFT; its value there is don't-care for consumers.

Reset
REQ-030 SHALL, while r_n=0 and independent of t_clk, force the following:
- state=IDLE;
- counter, seen, mode flag, shift register, result register, out_data and out_ovf all zero;
- out_valid=0 and busy=0;
- in_ready=1 from the first edge after r_n rises, and combinationally in IDLE.
REQ-031 SHALL, when r_n is asserted during SHIFT or DONE, discard the word in flight, produce no result, and return to IDLE.
REQ-032 SHALL accept a word on the first rising edge after r_n deasserts if in_valid=1.

Verification
REQ-033 Negate, WIDTH=8: in_data=0x06, in_neg=1 -> out_valid exactly 8 cycles after acceptance, out_data=0xFA, out_ovf=0.
REQ-034 Pass-through and zero: 0x5A with in_neg=0 -> 0x5A; 0x00 with in_neg=1 -> 0x00, out_ovf=0.
REQ-035 Boundaries:
- 0x80 with in_neg=1 -> 0x80, out_ovf=1.
- 0xFF with in_neg=1 -> 0x01.
- 0x01 with in_neg=1 -> 0xFF.
REQ-036 Backpressure: out_ready=0 for 20 cycles in DONE -> out_valid and out_data stable, in_ready=0 throughout. Second word with in_valid held high -> accepted the cycle after the handshake plus one IDLE cycle.
REQ-037 Reset mid-word: r_n=0 at bit 3 of 0x06 -> outputs zero immediately, no out_valid. After release, 0x03 with in_neg=1 -> 0xFD.
REQ-038 Random regression: 1000 random words and in_neg values with random valid/ready gaps -> every result equals (-x) mod 2^WIDTH or x as selected, with no loss or duplication.
